// File: rtl/draw_pkg.sv
// Shared types for the line-drawing blocks: stepping-core state encoding and dash pattern width.
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT_0 = 2'd1,
        INIT_1 = 2'd2,
        DRAW   = 2'd3
    } state_t;

    localparam int unsigned DASH_W = 16;

endpackage

// File: rtl/draw_line_clip_if.sv
// Controller-to-rasteriser bus: line request, clip window, and per-point pixel output.
// Optional dash pattern signals are present when DRAW_LINE_CLIP_DASH_EN is defined.
interface draw_line_clip_if
    import draw_pkg::*;
#(
    parameter int unsigned CORDW = 16,
    parameter int unsigned CNTW  = CORDW + 1
);
    logic                    start;
    logic                    abort;
    logic                    oe;
    logic signed [CORDW-1:0] x0, y0, x1, y1;
    logic signed [CORDW-1:0] cx0, cy0, cx1, cy1;
    logic signed [CORDW-1:0] x, y;
    logic                    drawing;
    logic                    busy;
    logic                    done;
    logic [CNTW-1:0]         cnt;
`ifdef DRAW_LINE_CLIP_DASH_EN
    logic [DASH_W-1:0]       pattern;
    logic                    pat_rst;
`endif

    modport master (
        output start, abort, oe, x0, y0, x1, y1, cx0, cy0, cx1, cy1,
`ifdef DRAW_LINE_CLIP_DASH_EN
        output pattern, pat_rst,
`endif
        input  x, y, drawing, busy, done, cnt
    );

    modport slave (
        input  start, abort, oe, x0, y0, x1, y1, cx0, cy0, cx1, cy1,
`ifdef DRAW_LINE_CLIP_DASH_EN
        input  pattern, pat_rst,
`endif
        output x, y, drawing, busy, done, cnt
    );

endinterface

// File: rtl/clip_test.sv
// Signed inclusive point-in-window test; an inverted window (c*0 > c*1) never contains a point.
module clip_test #(
    parameter int unsigned CORDW = 16
) (
    input  logic signed [CORDW-1:0] px,
    input  logic signed [CORDW-1:0] py,
    input  logic signed [CORDW-1:0] cx0,
    input  logic signed [CORDW-1:0] cy0,
    input  logic signed [CORDW-1:0] cx1,
    input  logic signed [CORDW-1:0] cy1,
    output logic                    inside_c
);

    assign inside_c = (px >= cx0) && (px <= cx1) && (py >= cy0) && (py <= cy1);

endmodule

// File: rtl/draw_line_clip.sv
// Bresenham line rasteriser with latched endpoints, per-line clip window, abort and drawn-pixel count.
// Define DRAW_LINE_CLIP_DASH_EN to add a 16-bit dash pattern gating which points are drawn.
module draw_line_clip
    import draw_pkg::*;
#(
    parameter int unsigned CORDW = 16,
    parameter int unsigned CNTW  = CORDW + 1
) (
    input  logic            clk,
    input  logic            rst,
    draw_line_clip_if.slave bus
);

    localparam int unsigned DW = CORDW + 1;
    localparam int unsigned EW = CORDW + 2;

    state_t                  state, state_n;
    logic                    load, init0, init1, step, fin, stop;
    logic signed [CORDW-1:0] xa, ya, xb, yb;
    logic signed [CORDW-1:0] wx0, wy0, wx1, wy1;
    logic signed [CORDW-1:0] x, y;
    logic                    right, busy, done;
    logic signed [DW-1:0]    dx, dy, err, err_n, ddx;
    logic signed [EW-1:0]    e2;
    logic                    movx, movy, at_end, swap_c, inside_c, drawing_c;
    logic [CNTW-1:0]         cnt;
`ifdef DRAW_LINE_CLIP_DASH_EN
    localparam int unsigned IW = $clog2(DASH_W);
    logic [DASH_W-1:0]       pat;
    logic [IW-1:0]           idx;
`endif

    clip_test #(.CORDW(CORDW)) u_clip (
        .px      (x),
        .py      (y),
        .cx0     (wx0),
        .cy0     (wy0),
        .cx1     (wx1),
        .cy1     (wy1),
        .inside_c(inside_c)
    );

    // Bresenham step decision and error update, all on sign-extended values
    always_comb begin
        ddx    = DW'(xb) - DW'(xa);
        e2     = EW'(err) <<< 1;
        movx   = e2 >= EW'(dy);
        movy   = e2 <= EW'(dx);
        err_n  = err + (movx ? dy : '0) + (movy ? dx : '0);
        at_end = (x == xb) && (y == yb);
        swap_c = bus.y0 > bus.y1;
    end

`ifdef DRAW_LINE_CLIP_DASH_EN
    assign drawing_c = (state == DRAW) && bus.oe && inside_c && pat[idx];
`else
    assign drawing_c = (state == DRAW) && bus.oe && inside_c;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and datapath strobes; abort outranks the end-point check
    always_comb begin
        state_n = state;
        load    = 1'b0;
        init0   = 1'b0;
        init1   = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        stop    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = INIT_0;
                end
            end
            INIT_0: begin
                if (bus.abort) begin
                    stop    = 1'b1;
                    state_n = IDLE;
                end else begin
                    init0   = 1'b1;
                    state_n = INIT_1;
                end
            end
            INIT_1: begin
                if (bus.abort) begin
                    stop    = 1'b1;
                    state_n = IDLE;
                end else begin
                    init1   = 1'b1;
                    state_n = DRAW;
                end
            end
            DRAW: begin
                if (bus.abort) begin
                    stop    = 1'b1;
                    state_n = IDLE;
                end else if (bus.oe) begin
                    if (at_end) begin
                        fin     = 1'b1;
                        state_n = IDLE;
                    end else begin
                        step    = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xa <= '0; ya <= '0; xb <= '0; yb <= '0;
            wx0 <= '0; wy0 <= '0; wx1 <= '0; wy1 <= '0;
            x <= '0; y <= '0;
            dx <= '0; dy <= '0; err <= '0;
            right <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
`ifdef DRAW_LINE_CLIP_DASH_EN
            pat <= '0;
            idx <= '0;
`endif
        end else begin
            done <= fin;
            if (load) begin
                // Order endpoints so the line always walks in +y
                if (swap_c) begin
                    xa <= bus.x1; ya <= bus.y1; xb <= bus.x0; yb <= bus.y0;
                    right <= bus.x1 < bus.x0;
                end else begin
                    xa <= bus.x0; ya <= bus.y0; xb <= bus.x1; yb <= bus.y1;
                    right <= bus.x0 < bus.x1;
                end
                wx0 <= bus.cx0; wy0 <= bus.cy0; wx1 <= bus.cx1; wy1 <= bus.cy1;
                busy <= 1'b1;
                cnt  <= '0;
`ifdef DRAW_LINE_CLIP_DASH_EN
                pat <= bus.pattern;
                idx <= '0;
`endif
            end
            if (stop || fin) busy <= 1'b0;
            if (init0) begin
                dx <= (ddx < 0) ? -ddx : ddx;
                dy <= DW'(ya) - DW'(yb);
            end
            if (init1) begin
                err <= dx + dy;
                x   <= xa;
                y   <= ya;
            end
            if (drawing_c && !stop && (cnt != '1)) cnt <= cnt + CNTW'(1);
            if (step) begin
                if (movx) x <= right ? x + CORDW'(1) : x - CORDW'(1);
                if (movy) y <= y + CORDW'(1);
                err <= err_n;
            end
`ifdef DRAW_LINE_CLIP_DASH_EN
            if (state == DRAW) begin
                if (bus.pat_rst)  idx <= '0;
                else if (bus.oe)  idx <= idx + IW'(1);
            end
`endif
        end
    end

    assign bus.x       = x;
    assign bus.y       = y;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.cnt     = cnt;
    assign bus.drawing = drawing_c;

endmodule
